// File: rtl/axis_adc_decimator.sv
// -----------------------------------------------------------------------------
// axis_adc_decimator
//
// Boxcar decimator for the signed ADC sample stream. Each window of
// 2^cfg_shift accepted samples is summed and arithmetically shifted down,
// producing one averaged word per window. Every cfg_len-th output carries
// tlast so the stream can feed a packetising DMA stage directly.
//
// Ports:
//   aclk, aresetn      clock, asynchronous active-low reset
//   enable             run/stop; log2_avg and packet_len latched on 0->1
//   log2_avg           window length exponent (clamped to MAX_LOG2_AVG)
//   packet_len         outputs per packet (0 = tlast never asserted)
//   s_axis_*           sample input stream (tdata, tvalid, tready)
//   m_axis_*           averaged output stream (tdata, tvalid, tready, tlast)
//   busy               high while running or while an output is pending
//   dbg_state_o        current FSM state (0 = IDLE, 1 = ACCUM)
//
// Handshake: a word moves on any rising aclk edge where tvalid and tready are
// both high. The output side holds tvalid/tdata/tlast stable until taken.
// s_axis_tready is only high in ACCUM while enable is high and the single
// output register is empty or being drained in the same cycle, so a window
// can complete while the previous result leaves, without a bubble.
// -----------------------------------------------------------------------------
module axis_adc_decimator #(
   parameter int DATA_WIDTH   = 32,
   parameter int MAX_LOG2_AVG = 10,
   parameter int PKT_WIDTH    = 16
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  enable,
   input  logic [3:0]            log2_avg,
   input  logic [PKT_WIDTH-1:0]  packet_len,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  busy,
   output logic                  dbg_state_o
);

   localparam int         AW        = DATA_WIDTH + MAX_LOG2_AVG;
   localparam int         CW        = MAX_LOG2_AVG + 1;
   localparam logic [3:0] MAX_SHIFT = 4'(MAX_LOG2_AVG);

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic                   enable_q;
   logic [3:0]             cfg_shift_q, cfg_shift_d;
   logic [PKT_WIDTH-1:0]   cfg_len_q, cfg_len_d;
   logic [PKT_WIDTH-1:0]   pkt_q, pkt_d;
   logic signed [AW-1:0]   acc_q, acc_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
   logic                   tvalid_q, tvalid_d;
   logic                   tlast_q, tlast_d;

   logic                   en_rise;
   logic                   in_hs;
   logic                   win_done;
   logic [CW-1:0]          win_last;
   logic signed [AW-1:0]   sum;
   logic [PKT_WIDTH-1:0]   pkt_inc;

   assign en_rise       = enable & ~enable_q;
   // Gating with enable keeps a sample from being taken in the cycle the
   // run is being stopped, since that partial window is thrown away anyway.
   assign s_axis_tready = (state_q == ACCUM) & enable & (~tvalid_q | m_axis_tready);
   assign in_hs         = s_axis_tvalid & s_axis_tready;

   // Sum including the sample on the bus, so the final sample of a window
   // goes straight into the result without an extra cycle.
   assign sum      = acc_q + {{MAX_LOG2_AVG{s_axis_tdata[DATA_WIDTH-1]}}, s_axis_tdata};
   assign win_last = (CW'(1) << cfg_shift_q) - CW'(1);
   assign win_done = (cnt_q == win_last);
   assign pkt_inc  = pkt_q + PKT_WIDTH'(1);

   always_comb begin
      state_d     = state_q;
      cfg_shift_d = cfg_shift_q;
      cfg_len_d   = cfg_len_q;
      pkt_d       = pkt_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      tdata_d     = tdata_q;
      tvalid_d    = tvalid_q;
      tlast_d     = tlast_q;

      // Drain first; a load below in the same cycle overrides it.
      if (m_axis_tready) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (en_rise) begin
               state_d     = ACCUM;
               cfg_shift_d = (log2_avg > MAX_SHIFT) ? MAX_SHIFT : log2_avg;
               cfg_len_d   = packet_len;
               acc_d       = '0;
               cnt_d       = '0;
               pkt_d       = '0;
            end
         end
         ACCUM: begin
            if (!enable) begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               pkt_d   = '0;
            end else if (in_hs) begin
               if (win_done) begin
                  acc_d    = '0;
                  cnt_d    = '0;
                  tvalid_d = 1'b1;
                  tdata_d  = DATA_WIDTH'(sum >>> cfg_shift_q);
                  if ((cfg_len_q != '0) && (pkt_inc == cfg_len_q)) begin
                     tlast_d = 1'b1;
                     pkt_d   = '0;
                  end else begin
                     tlast_d = 1'b0;
                     pkt_d   = pkt_inc;
                  end
               end else begin
                  acc_d = sum;
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         enable_q    <= 1'b0;
         cfg_shift_q <= '0;
         cfg_len_q   <= '0;
         pkt_q       <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         tdata_q     <= '0;
         tvalid_q    <= 1'b0;
         tlast_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         enable_q    <= enable;
         cfg_shift_q <= cfg_shift_d;
         cfg_len_q   <= cfg_len_d;
         pkt_q       <= pkt_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         tdata_q     <= tdata_d;
         tvalid_q    <= tvalid_d;
         tlast_q     <= tlast_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign busy          = (state_q == ACCUM) | tvalid_q;
   assign dbg_state_o   = (state_q == ACCUM);

endmodule

// File: tb/tb_axis_adc_decimator.sv
// -----------------------------------------------------------------------------
// tb_axis_adc_decimator
//
// Bench for axis_adc_decimator: clock/reset block, driver tasks, a scoreboard
// fed either by table constants or by a window-averaging reference model,
// hand-written multi-cycle sequences and a randomized phase.
// -----------------------------------------------------------------------------
module tb_axis_adc_decimator;

   localparam int DW = 32;

   logic          aclk;
   logic          aresetn;
   logic          enable;
   logic [3:0]    log2_avg;
   logic [15:0]   packet_len;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic          busy;
   logic          dbg_state;

   int            total;
   int            bad;
   logic [DW:0]   exp_q[$];   // {tlast, tdata}
   logic [DW:0]   mon_e;
   bit            use_model;
   bit            rand_rdy;

   // reference model state
   int            m_shift;
   int            m_len;
   int            m_pkt;
   int            win_n;
   longint        win_sum;

   typedef struct {
      logic [3:0]         l2;
      logic [15:0]        len;
      logic [3:0][DW-1:0] s;
      logic [DW-1:0]      exp_d;
      logic               exp_l;
   } vec_t;

   vec_t tbl[7];

   axis_adc_decimator #(
      .DATA_WIDTH(32),
      .MAX_LOG2_AVG(10),
      .PKT_WIDTH(16)
   ) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .enable       (enable),
      .log2_avg     (log2_avg),
      .packet_len   (packet_len),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast (m_axis_tlast),
      .busy         (busy),
      .dbg_state_o  (dbg_state)
   );

   // ---------------- clock ----------------
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_start(input logic [3:0] l2, input logic [15:0] len);
      m_shift = (l2 > 4'd10) ? 10 : int'(l2);
      m_len   = int'(len);
      m_pkt   = 0;
      win_n   = 0;
      win_sum = 0;
   endtask

   task automatic model_abort();
      m_pkt   = 0;
      win_n   = 0;
      win_sum = 0;
   endtask

   // Average = floor(sum / window); packet position counted per output.
   task automatic model_sample(input logic [DW-1:0] d);
      longint avg;
      logic   last;
      win_sum += longint'($signed(d));
      win_n++;
      if (win_n == (1 << m_shift)) begin
         avg = win_sum >>> m_shift;
         m_pkt++;
         last = (m_len != 0) && (m_pkt == m_len);
         if (last) m_pkt = 0;
         exp_q.push_back({last, avg[DW-1:0]});
         win_n   = 0;
         win_sum = 0;
      end
   endtask

   // ---------------- monitors (sample on falling edge) ----------------
   initial begin
      forever begin
         @(negedge aclk);
         if (use_model && s_axis_tvalid && s_axis_tready) model_sample(s_axis_tdata);
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL out_unexpected: got %h expected none", {m_axis_tlast, m_axis_tdata});
            end else begin
               mon_e = exp_q.pop_front();
               check("out_word", 64'({m_axis_tlast, m_axis_tdata}), 64'(mon_e));
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge aclk);
         #1;
         if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d);
      int n;
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!s_axis_tready && n < 3000) begin
         @(negedge aclk);
         n++;
      end
      if (!s_axis_tready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got tready=0 expected tready=1");
      end
      tick();
   endtask

   task automatic idle_in();
      s_axis_tvalid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         tick();
         n++;
      end
      check("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   // Config is latched on the enable edge, then scrambled to show later
   // changes are ignored.
   task automatic start(input logic [3:0] l2, input logic [15:0] len);
      log2_avg   = l2;
      packet_len = len;
      enable     = 1'b1;
      if (use_model) model_start(l2, len);
      tick();
      log2_avg   = 4'($urandom);
      packet_len = 16'($urandom);
   endtask

   task automatic stop();
      enable = 1'b0;
      if (use_model) model_abort();
      tick();
      tick();
   endtask

   task automatic set_vec(input int k, input logic [3:0] l2, input logic [15:0] len,
                          input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] c, input logic [DW-1:0] d,
                          input logic [DW-1:0] e, input logic l);
      tbl[k].l2    = l2;
      tbl[k].len   = len;
      tbl[k].s[0]  = a;
      tbl[k].s[1]  = b;
      tbl[k].s[2]  = c;
      tbl[k].s[3]  = d;
      tbl[k].exp_d = e;
      tbl[k].exp_l = l;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int nsamp;
      int gap;
      logic [DW-1:0] d;

      total = 0;
      bad   = 0;
      use_model = 1'b0;
      rand_rdy  = 1'b0;
      aresetn = 1'b0;
      enable = 1'b0;
      log2_avg = '0;
      packet_len = '0;
      s_axis_tdata = '0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;

      set_vec(0, 4'd2, 16'd1, 32'd10, 32'd20, 32'd30, 32'd41, 32'd25, 1'b1);
      set_vec(1, 4'd2, 16'd0, -32'sd1, -32'sd2, -32'sd3, -32'sd3, -32'sd3, 1'b0);
      set_vec(2, 4'd1, 16'd1, 32'd7, 32'd8, 32'd0, 32'd0, 32'd7, 1'b1);
      set_vec(3, 4'd1, 16'd0, -32'sd7, -32'sd8, 32'd0, 32'd0, -32'sd8, 1'b0);
      set_vec(4, 4'd2, 16'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1, 32'd0, 32'h3FFFFFFF, 1'b1);
      set_vec(5, 4'd2, 16'd0, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
              32'h80000000, 1'b0);
      set_vec(6, 4'd0, 16'd1, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 32'hDEADBEEF, 1'b1);

      // reset
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;
      @(negedge aclk);
      check("rst_s_tready", 64'(s_axis_tready), 64'd0);
      check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
      check("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
      tick();

      // pass-through, tlast on the 4th output
      m_axis_tready = 1'b1;
      for (int i = 1; i <= 5; i++) exp_q.push_back({(i == 4), 32'(i)});
      start(4'd0, 16'd4);
      check("pt_busy", 64'(busy), 64'd1);
      check("pt_state", 64'(dbg_state), 64'd1);
      for (int i = 1; i <= 5; i++) begin
         send(32'(i));
         check("pt_lat_valid", 64'(m_axis_tvalid), 64'd1);
         check("pt_lat_data", 64'(m_axis_tdata), 64'(i));
      end
      idle_in();
      wait_drain();
      stop();
      check("pt_busy_off", 64'(busy), 64'd0);

      // averaging table
      for (int k = 0; k < 7; k++) begin
         exp_q.push_back({tbl[k].exp_l, tbl[k].exp_d});
         start(tbl[k].l2, tbl[k].len);
         for (int i = 0; i < (1 << tbl[k].l2); i++) send(tbl[k].s[i]);
         idle_in();
         wait_drain();
         stop();
      end

      // backpressure
      start(4'd0, 16'd0);
      m_axis_tready = 1'b0;
      exp_q.push_back({1'b0, 32'h8BADF00D});
      exp_q.push_back({1'b0, 32'h0023FF42});
      send(32'h8BADF00D);
      s_axis_tdata = 32'h0023FF42;
      repeat (5) begin
         @(negedge aclk);
         check("bp_hold_data", 64'(m_axis_tdata), 64'h8BADF00D);
         check("bp_hold_valid", 64'(m_axis_tvalid), 64'd1);
         check("bp_s_tready", 64'(s_axis_tready), 64'd0);
      end
      tick();
      m_axis_tready = 1'b1;
      @(negedge aclk);
      check("bp_drain_ready", 64'(s_axis_tready), 64'd1);
      tick();
      idle_in();
      check("bp_next_valid", 64'(m_axis_tvalid), 64'd1);
      check("bp_next_data", 64'(m_axis_tdata), 64'h0023FF42);
      wait_drain();
      stop();

      // clamp to 1024-sample window, full-scale input
      use_model = 1'b1;
      start(4'd15, 16'd0);
      for (int i = 0; i < 1024; i++) begin
         send(32'h7FFFFFFF);
         if (i == 1022) check("clamp_no_early", 64'(m_axis_tvalid), 64'd0);
      end
      idle_in();
      check("clamp_valid", 64'(m_axis_tvalid), 64'd1);
      check("clamp_data", 64'(m_axis_tdata), 64'h7FFFFFFF);
      wait_drain();
      stop();
      use_model = 1'b0;

      // abort: one full window, then a partial one, then a new config
      exp_q.push_back({1'b0, 32'd4});
      start(4'd3, 16'd2);
      for (int i = 1; i <= 8; i++) send(32'(i));
      for (int i = 0; i < 5; i++) send(32'd10);
      idle_in();
      wait_drain();
      enable = 1'b0;
      tick();
      tick();
      check("abort_no_out", 64'(m_axis_tvalid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_s_tready", 64'(s_axis_tready), 64'd0);
      exp_q.push_back({1'b0, 32'd7});
      exp_q.push_back({1'b1, 32'd3});
      start(4'd1, 16'd2);
      send(32'd6);
      send(32'd8);
      send(32'd2);
      send(32'd4);
      idle_in();
      wait_drain();
      stop();

      // asynchronous reset while an output is pending
      start(4'd1, 16'd0);
      m_axis_tready = 1'b0;
      send(32'd4);
      send(32'd6);
      idle_in();
      check("rst_pre_valid", 64'(m_axis_tvalid), 64'd1);
      #2 aresetn = 1'b0;
      #1;
      check("arst_valid", 64'(m_axis_tvalid), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_tdata", 64'(m_axis_tdata), 64'd0);
      enable = 1'b0;
      tick();
      aresetn = 1'b1;
      m_axis_tready = 1'b1;
      tick();
      exp_q.push_back({1'b0, 32'd15});
      start(4'd1, 16'd0);
      send(32'd10);
      send(32'd20);
      idle_in();
      wait_drain();
      stop();

      // randomized sessions against the reference model
      use_model = 1'b1;
      for (int s = 0; s < 6; s++) begin
         rand_rdy = 1'b1;
         start(4'($urandom_range(0, 4)), 16'($urandom_range(0, 4)));
         nsamp = $urandom_range(20, 80);
         for (int i = 0; i < nsamp; i++) begin
            gap = $urandom_range(0, 2);
            idle_in();
            repeat (gap) tick();
            if ($urandom_range(0, 2) == 0) d = 32'($urandom_range(0, 200)) - 32'd100;
            else d = $urandom;
            send(d);
         end
         idle_in();
         rand_rdy = 1'b0;
         tick();
         m_axis_tready = 1'b1;
         wait_drain();
         stop();
      end
      use_model = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
